// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat hand-scoring blocks: hand FSM states,
// rank code limits and default scoring parameters.
package baccarat_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } hand_state_e;

  localparam int unsigned RANK_ACE  = 1;
  localparam int unsigned RANK_KING = 13;

  localparam int DEFAULT_MOD      = 10;
  localparam int DEFAULT_FACE_MAX = 9;

endpackage

// File: rtl/score_accumulator_if.sv
// Card offer / hand status bundle around score_accumulator; the dealer side
// drives the offer, the accumulator side reports the hand status.
interface score_accumulator_if #(
  parameter int CARD_W  = 4,
  parameter int SCORE_W = 4,
  parameter int COUNT_W = 2
);

  logic               clear;
  logic               card_valid;
  logic [CARD_W-1:0]  card;
  logic               card_ready;
  logic [SCORE_W-1:0] score;
  logic [COUNT_W-1:0] count;
  logic               natural;
  logic               full;
  logic               illegal;

  modport master (
    output clear, card_valid, card,
    input  card_ready, score, count, natural, full, illegal
  );

  modport slave (
    input  clear, card_valid, card,
    output card_ready, score, count, natural, full, illegal
  );

endinterface

// File: rtl/card_value.sv
// Combinational rank-to-points mapping: ranks above FACE_MAX score zero,
// codes outside ace..king are flagged as illegal.
module card_value
  import baccarat_pkg::*;
#(
  parameter int CARD_W   = 4,
  parameter int VAL_W    = 4,
  parameter int FACE_MAX = DEFAULT_FACE_MAX
) (
  input  logic [CARD_W-1:0] rank_i,
  output logic [VAL_W-1:0]  value_o,
  output logic              illegal_o
);

  logic [31:0] rank_ext;

  always_comb begin
    rank_ext  = 32'(rank_i);
    illegal_o = (rank_ext < RANK_ACE) || (rank_ext > RANK_KING);
    // FACE_MAX < MOD guarantees a scoring rank fits in VAL_W bits
    if (rank_ext > 32'(FACE_MAX)) begin
      value_o = '0;
    end else begin
      value_o = VAL_W'(rank_i);
    end
  end

endmodule

// File: rtl/score_accumulator.sv
// Baccarat hand accumulator: accepts up to NUM_CARDS cards, keeps the running
// total mod MOD, and reports natural / full / sticky illegal-code status.
module score_accumulator
  import baccarat_pkg::*;
#(
  parameter int NUM_CARDS = 3,
  parameter int CARD_W    = 4,
  parameter int FACE_MAX  = DEFAULT_FACE_MAX,
  parameter int MOD       = DEFAULT_MOD
) (
  input  logic                             slow_clock,
  input  logic                             resetb,
  input  logic                             clear,
  input  logic                             card_valid,
  input  logic [CARD_W-1:0]                card,
  output logic                             card_ready,
  output logic [$clog2(MOD)-1:0]           score,
  output logic [$clog2(NUM_CARDS+1)-1:0]   count,
  output logic                             natural,
  output logic                             full,
  output logic                             illegal
);

  localparam int SCORE_W = $clog2(MOD);
  localparam int COUNT_W = $clog2(NUM_CARDS + 1);
  localparam int SUM_W   = SCORE_W + 1;

  hand_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               natural_q, natural_d;
  logic               illegal_q, illegal_d;

  logic [SCORE_W-1:0] card_val;
  logic               card_bad;
  logic               offered;
  logic               accept;
  logic [SUM_W-1:0]   sum;
  logic [SUM_W-1:0]   sum_wrapped;

  card_value #(
    .CARD_W   (CARD_W),
    .VAL_W    (SCORE_W),
    .FACE_MAX (FACE_MAX)
  ) u_card_value (
    .rank_i    (card),
    .value_o   (card_val),
    .illegal_o (card_bad)
  );

  assign full       = (state_q == FULL);
  assign card_ready = !full;
  assign score      = score_q;
  assign count      = count_q;
  assign natural    = natural_q;
  assign illegal    = illegal_q;

  // Both operands are below MOD, so one conditional subtract suffices and
  // the extra sum bit keeps MOD == 2**SCORE_W from overflowing.
  always_comb begin
    sum         = SUM_W'(score_q) + SUM_W'(card_val);
    sum_wrapped = (sum >= SUM_W'(MOD)) ? (sum - SUM_W'(MOD)) : sum;
  end

  always_comb begin
    offered = card_valid && card_ready && !clear;
    accept  = offered && !card_bad;
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    count_d   = count_q;
    illegal_d = illegal_q;

    if (clear) begin
      state_d   = EMPTY;
      score_d   = '0;
      count_d   = '0;
      illegal_d = 1'b0;
    end else begin
      if (offered && card_bad) begin
        illegal_d = 1'b1;
      end
      if (accept) begin
        score_d = SCORE_W'(sum_wrapped);
        count_d = count_q + COUNT_W'(1);
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = (count_d == COUNT_W'(NUM_CARDS)) ? FULL : PARTIAL;
          end
        end
        PARTIAL: begin
          if (accept && (count_d == COUNT_W'(NUM_CARDS))) begin
            state_d = FULL;
          end
        end
        FULL: begin
          state_d = FULL;
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    natural_d = (count_d == COUNT_W'(2)) && (32'(score_d) >= 32'(MOD - 2));
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q   <= EMPTY;
      score_q   <= '0;
      count_q   <= '0;
      natural_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      count_q   <= count_d;
      natural_q <= natural_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_score_accumulator.sv
// Bench for score_accumulator: default and (5 cards, mod 16) instances driven
// in lockstep and compared against a running-total model of the hand rules.
module tb_score_accumulator;
  import baccarat_pkg::*;

  localparam int A_N = 3, A_MOD = 10, A_FM = 9;
  localparam int B_N = 5, B_MOD = 16, B_FM = 13;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;

  always #5 slow_clock = ~slow_clock;

  score_accumulator_if #(.CARD_W(4), .SCORE_W(4), .COUNT_W(2)) ia ();
  score_accumulator_if #(.CARD_W(4), .SCORE_W(4), .COUNT_W(3)) ib ();

  score_accumulator dut_a (
    .slow_clock (slow_clock), .resetb (resetb), .clear (ia.clear),
    .card_valid (ia.card_valid), .card (ia.card), .card_ready (ia.card_ready),
    .score (ia.score), .count (ia.count), .natural (ia.natural),
    .full (ia.full), .illegal (ia.illegal)
  );

  score_accumulator #(.NUM_CARDS(B_N), .CARD_W(4), .FACE_MAX(B_FM), .MOD(B_MOD)) dut_b (
    .slow_clock (slow_clock), .resetb (resetb), .clear (ib.clear),
    .card_valid (ib.card_valid), .card (ib.card), .card_ready (ib.card_ready),
    .score (ib.score), .count (ib.count), .natural (ib.natural),
    .full (ib.full), .illegal (ib.illegal)
  );

  int checks = 0;
  int passed = 0;

  // Model: hand kept as an unbounded point total and a card count.
  int NC[2] = '{A_N, B_N};
  int MD[2] = '{A_MOD, B_MOD};
  int FM[2] = '{A_FM, B_FM};
  int m_sum[2];
  int m_cnt[2];
  bit m_ill[2];
  bit m_nat[2];

  task automatic model_apply(input bit rst, input bit clr, input bit v, input int c);
    for (int k = 0; k < 2; k++) begin
      if (!rst || clr) begin
        m_sum[k] = 0;
        m_cnt[k] = 0;
        m_ill[k] = 1'b0;
      end else if (v && m_cnt[k] < NC[k]) begin
        if (c == 0 || c > 13) begin
          m_ill[k] = 1'b1;
        end else begin
          m_sum[k] += (c > FM[k]) ? 0 : c;
          m_cnt[k]++;
        end
      end
      m_nat[k] = (m_cnt[k] == 2) && ((m_sum[k] % MD[k]) >= MD[k] - 2);
    end
  endtask

  function automatic logic [9:0] exp_a();
    return {4'(m_sum[0] % A_MOD), 2'(m_cnt[0]), m_nat[0],
            m_cnt[0] == A_N, m_ill[0], m_cnt[0] != A_N};
  endfunction

  function automatic logic [10:0] exp_b();
    return {4'(m_sum[1] % B_MOD), 3'(m_cnt[1]), m_nat[1],
            m_cnt[1] == B_N, m_ill[1], m_cnt[1] != B_N};
  endfunction

  function automatic logic [9:0] obs_a();
    return {ia.score, ia.count, ia.natural, ia.full, ia.illegal, ia.card_ready};
  endfunction

  function automatic logic [10:0] obs_b();
    return {ib.score, ib.count, ib.natural, ib.full, ib.illegal, ib.card_ready};
  endfunction

  task automatic step(input bit rst, input bit clr, input bit v, input int c);
    resetb        = rst;
    ia.clear      = clr;
    ib.clear      = clr;
    ia.card_valid = v;
    ib.card_valid = v;
    ia.card       = 4'(c);
    ib.card       = 4'(c);
    @(posedge slow_clock);
    model_apply(rst, clr, v, c);
    #1;
  endtask

  task automatic test_reset();
    step(0, 1, 1, 5);
    step(0, 0, 1, 7);
    checks++;
    if (obs_a() !== 10'b0000_00_0001) $display("FAIL reset_a: got %h want %h", obs_a(), 10'b0000_00_0001);
    else passed++;
    checks++;
    if (obs_b() !== exp_b()) $display("FAIL reset_b: got %h want %h", obs_b(), exp_b());
    else passed++;
  endtask

  task automatic test_default_hand();
    int exp_s[3] = '{0, 9, 4};
    int cards[3] = '{13, 9, 5};
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, cards[i]);
      checks++;
      if (ia.score !== 4'(exp_s[i]) || ia.count !== 2'(i + 1))
        $display("FAIL default_hand[%0d]: got score %0d count %0d want %0d %0d",
                 i, ia.score, ia.count, exp_s[i], i + 1);
      else passed++;
    end
    checks++;
    if ({ia.full, ia.card_ready} !== 2'b10 || obs_a() !== exp_a())
      $display("FAIL default_full: got %h want %h", obs_a(), exp_a());
    else passed++;
  endtask

  task automatic test_natural();
    step(1, 1, 0, 0);
    step(1, 0, 1, 4);
    step(1, 0, 1, 4);
    checks++;
    if ({ia.score, ia.count, ia.natural} !== {4'd8, 2'd2, 1'b1})
      $display("FAIL natural_set: got %0d/%0d/%b want 8/2/1", ia.score, ia.count, ia.natural);
    else passed++;
    step(1, 0, 1, 1);
    checks++;
    if ({ia.score, ia.natural} !== {4'd9, 1'b0} || obs_b() !== exp_b())
      $display("FAIL natural_clr: got %0d/%b b=%h want 9/0 b=%h", ia.score, ia.natural, obs_b(), exp_b());
    else passed++;
  endtask

  task automatic test_full_hold();
    step(1, 1, 0, 0);
    step(1, 0, 1, 7);
    step(1, 0, 1, 8);
    step(1, 0, 1, 2);
    step(1, 0, 1, 6);
    checks++;
    if ({ia.score, ia.count, ia.full} !== {4'd7, 2'd3, 1'b1})
      $display("FAIL full_hold: got %0d/%0d/%b want 7/3/1", ia.score, ia.count, ia.full);
    else passed++;
    step(1, 0, 1, 0);
    checks++;
    if (obs_a() !== exp_a() || ia.illegal !== 1'b0)
      $display("FAIL full_ignore_bad: got %h want %h", obs_a(), exp_a());
    else passed++;
  endtask

  task automatic test_clear_priority();
    step(1, 1, 0, 0);
    step(1, 0, 1, 6);
    step(1, 0, 1, 3);
    checks++;
    if (ia.score !== 4'd9) $display("FAIL clear_pre: got %0d want 9", ia.score);
    else passed++;
    step(1, 1, 1, 5);
    checks++;
    if ({ia.score, ia.count} !== 6'd0 || obs_b() !== exp_b())
      $display("FAIL clear_prio: got a=%h b=%h want a=0 b=%h", {ia.score, ia.count}, obs_b(), exp_b());
    else passed++;
  endtask

  task automatic test_illegal();
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    checks++;
    if ({ia.illegal, ia.count} !== {1'b1, 2'd0})
      $display("FAIL illegal_zero: got %b/%0d want 1/0", ia.illegal, ia.count);
    else passed++;
    step(1, 0, 1, 14);
    checks++;
    if ({ia.illegal, ia.count, ia.score} !== {1'b1, 2'd0, 4'd0} || obs_b() !== exp_b())
      $display("FAIL illegal_14: got %b/%0d/%0d want 1/0/0", ia.illegal, ia.count, ia.score);
    else passed++;
    step(1, 1, 0, 0);
    checks++;
    if (ia.illegal !== 1'b0 || ib.illegal !== 1'b0)
      $display("FAIL illegal_clear: got %b/%b want 0/0", ia.illegal, ib.illegal);
    else passed++;
  endtask

  task automatic test_big_config();
    int cards[5] = '{13, 13, 12, 1, 1};
    int exp_s[5] = '{13, 10, 6, 7, 8};
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, cards[i]);
      checks++;
      if (ib.score !== 4'(exp_s[i]) || ib.count !== 3'(i + 1))
        $display("FAIL big_hand[%0d]: got score %0d count %0d want %0d %0d",
                 i, ib.score, ib.count, exp_s[i], i + 1);
      else passed++;
    end
    checks++;
    if (ib.full !== 1'b1 || obs_a() !== exp_a())
      $display("FAIL big_full: got full %b a=%h want 1 a=%h", ib.full, obs_a(), exp_a());
    else passed++;
    step(0, 0, 0, 0);
    checks++;
    if ({ib.score, ib.count, ib.natural, ib.full, ib.illegal} !== 11'd0)
      $display("FAIL big_reset: got %h want 0", obs_b());
    else passed++;
    step(1, 0, 1, 3);
    checks++;
    if ({ib.score, ib.count} !== {4'd3, 3'd1})
      $display("FAIL big_after_reset: got %0d/%0d want 3/1", ib.score, ib.count);
    else passed++;
  endtask

  task automatic test_random();
    bit rst, clr, v;
    int c;
    int errs_a = 0;
    int errs_b = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      clr = ($urandom_range(0, 19) == 0);
      v   = ($urandom_range(0, 9) < 7);
      c   = $urandom_range(0, 15);
      step(rst, clr, v, c);
      checks++;
      if (obs_a() !== exp_a()) begin
        if (errs_a < 5) $display("FAIL random_a[%0d]: got %h want %h", i, obs_a(), exp_a());
        errs_a++;
      end else passed++;
      checks++;
      if (obs_b() !== exp_b()) begin
        if (errs_b < 5) $display("FAIL random_b[%0d]: got %h want %h", i, obs_b(), exp_b());
        errs_b++;
      end else passed++;
    end
  endtask

  initial begin
    ia.clear = 1'b0; ia.card_valid = 1'b0; ia.card = '0;
    ib.clear = 1'b0; ib.card_valid = 1'b0; ib.card = '0;
    test_reset();
    test_default_hand();
    test_natural();
    test_full_hold();
    test_clear_priority();
    test_illegal();
    test_big_config();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/score_accumulator.md
SCORE_ACCUMULATOR -- requirements
Module: score_accumulator

Interface
REQ-001 SHALL have parameter NUM_CARDS, default 3, meaning the maximum number of cards per hand (range 2..15).
REQ-002 SHALL have parameter CARD_W, default 4, meaning the card rank code width.
REQ-003 SHALL have parameter FACE_MAX, default 9, meaning ranks above this value score 0 (constraint: FACE_MAX < MOD).
REQ-004 SHALL have parameter MOD, default 10, meaning the score modulus.
REQ-005 SHALL have port slow_clock, input, 1, the sole clock; all state changes occur on its rising edge.
REQ-006 SHALL have port resetb, input, 1, a synchronous active-low reset.
REQ-007 SHALL have port clear, input, 1, a synchronous start-new-hand request.
REQ-008 SHALL have port card_valid, input, 1, indicating a card is offered.
REQ-009 SHALL have port card, input, CARD_W, the offered rank code (0 = no card; 1 = A; 11..13 = J/Q/K).
REQ-010 SHALL have port card_ready, output, 1, indicating the block can accept a card.
REQ-011 SHALL have port score, output, $clog2(MOD), the running hand total mod MOD.
REQ-012 SHALL have port count, output, $clog2(NUM_CARDS+1), the number of cards accepted.
REQ-013 SHALL have port natural, output, 1, asserted when count==2 and score>=MOD-2.
REQ-014 SHALL have port full, output, 1, asserted when count==NUM_CARDS.
REQ-015 SHALL have port illegal, output, 1, a sticky flag for an offered card code of 0 or greater than 13.

Function
REQ-016 Handshake: a card SHALL be accepted on a rising edge with card_valid && card_ready && clear==0 && resetb==1.
REQ-017 card_ready SHALL equal !full, combinationally, and SHALL NOT depend on card_valid.
REQ-018 Card value SHALL be 0 if rank > FACE_MAX, else the rank.
REQ-019 On acceptance, score SHALL become (score + value) mod MOD, computed as a single conditional subtract of MOD, with no width overflow at maximum parameters.
REQ-020 Latency: score and count SHALL reflect an accepted card on the edge of acceptance, i.e. be visible the following cycle.
REQ-021 An illegal code (0 or >13) offered with card_valid && card_ready SHALL NOT be accepted: score and count unchanged, illegal set to 1.
REQ-022 FSM states SHALL be EMPTY (count 0), PARTIAL (0 < count < NUM_CARDS), and FULL (count == NUM_CARDS).
REQ-023 FSM transitions: EMPTY->PARTIAL on first accept; PARTIAL->FULL on the accept reaching NUM_CARDS; PARTIAL->PARTIAL otherwise; any state->EMPTY on clear.
REQ-024 In FULL, card_valid SHALL be ignored (no wrap-around), and score/count SHALL hold.
REQ-025 clear SHALL take priority over a simultaneous card: score=0, count=0, illegal=0, and the card is not accepted.
REQ-026 natural SHALL be a registered output, updated in the same cycle as count and score.

Reset
REQ-027 resetb==0 at a rising edge SHALL force the FSM to EMPTY, score=0, count=0, natural=0, illegal=0, and full=0, overriding clear and card_valid.
REQ-028 Reset asserted mid-hand SHALL discard all accumulated state; the first card after reset release SHALL be treated as card one.

Structure
REQ-029 A shared baccarat_pkg SHALL hold the FSM state enum, rank constants (RANK_ACE=1, RANK_KING=13), and the default MOD and FACE_MAX.
REQ-030 A combinational sub-module card_value SHALL map rank to score value and flag illegal codes; score_accumulator SHALL instantiate it once.

Verification
REQ-031 Defaults, cards 13, 9, 5 accepted on consecutive cycles -> score 0, 9, 4; count 1, 2, 3; full=1 and card_ready=0 after the third.
REQ-032 Cards 4, 4 -> score 8, count 2, natural=1; then card 1 -> score 9, natural=0.
REQ-033 Hand full (3 cards: 7, 8, 2, giving score 7) plus a 4th card 6 -> score stays 7, count stays 3.
REQ-034 After cards 6, 3 (score 9), clear=1 with card_valid=1 and card=5 in the same cycle -> score 0, count 0, card not accepted.
REQ-035 Card code 0, then code 14 -> illegal=1, count 0; clear -> illegal=0.
REQ-036 NUM_CARDS=5, MOD=16, FACE_MAX=13, cards 13, 13, 12, 1, 1 -> score 13, 10, 6, 7, 8; full=1; then resetb=0 for one cycle -> all outputs 0.
